// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner. It drives the columns and synchronizes the rows, then
// debounces the press and release of a single key and keeps a two-digit history.
module keypad_scan_ctrl #(
   parameter int SCAN_CYCLES     = 4,
   parameter int DEBOUNCE_CYCLES = 960000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SC_W-1:0] DWELL_LAST = SC_W'(SCAN_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_SCAN        = 2'd0,
      S_DEB_PRESS   = 2'd1,
      S_HELD        = 2'd2,
      S_DEB_RELEASE = 2'd3
   } state_t;

   state_t          state_q;
   logic [1:0]      col_q;
   logic [1:0]      row_q;
   logic [SC_W-1:0] dwell_q;
   logic [DB_W-1:0] dbcnt_q;
   logic [3:0]      col_n_q;
   logic [3:0]      key_code_q;
   logic            key_valid_q;
   logic            key_held_q;
   logic [3:0]      digit_new_q;
   logic [3:0]      digit_old_q;
   logic [3:0]      row_meta_q;
   logic [3:0]      row_sync_q;

   logic [3:0]      rows;
   logic [3:0]      row_onehot;
   logic            hit;
   logic [1:0]      hit_row;
   logic [1:0]      col_inc;
   logic            dwell_last;
   logic            db_last;
   logic            key_down;

   function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'hE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] c);
      return ~(4'b0001 << c);
   endfunction

   // Two-flop synchronizer; idle value is all rows released.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         row_meta_q <= row_n;
         row_sync_q <= row_meta_q;
      end
   end

   assign rows       = ~row_sync_q;
   assign row_onehot = 4'b0001 << row_q;
   assign col_inc    = col_q + 2'd1;
   assign dwell_last = (dwell_q == DWELL_LAST);
   assign db_last    = (dbcnt_q == DB_LAST);
   assign key_down   = rows[row_q];

   // Only a single asserted row is a usable hit; ghosting patterns read as no key.
   always_comb begin
      hit     = 1'b1;
      hit_row = 2'd0;
      case (rows)
         4'b0001: hit_row = 2'd0;
         4'b0010: hit_row = 2'd1;
         4'b0100: hit_row = 2'd2;
         4'b1000: hit_row = 2'd3;
         default: hit     = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_SCAN;
         col_q       <= 2'd0;
         col_n_q     <= 4'b1110;
         row_q       <= 2'd0;
         dwell_q     <= '0;
         dbcnt_q     <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         digit_new_q <= 4'h0;
         digit_old_q <= 4'h0;
      end else begin
         key_valid_q <= 1'b0;
         case (state_q)
            S_SCAN: begin
               if (dwell_last && hit) begin
                  row_q   <= hit_row;
                  dwell_q <= '0;
                  dbcnt_q <= '0;
                  state_q <= S_DEB_PRESS;
               end else if (dwell_last) begin
                  col_q   <= col_inc;
                  col_n_q <= col_drive(col_inc);
                  dwell_q <= '0;
               end else begin
                  dwell_q <= dwell_q + SC_W'(1);
               end
            end
            S_DEB_PRESS: begin
               if (!db_last) begin
                  dbcnt_q <= dbcnt_q + DB_W'(1);
               end else if (rows == row_onehot) begin
                  state_q     <= S_HELD;
                  key_code_q  <= key_lut(row_q, col_q);
                  key_valid_q <= 1'b1;
                  key_held_q  <= 1'b1;
                  digit_old_q <= digit_new_q;
                  digit_new_q <= key_lut(row_q, col_q);
               end else begin
                  state_q <= S_SCAN;
                  col_q   <= col_inc;
                  col_n_q <= col_drive(col_inc);
                  dwell_q <= '0;
                  dbcnt_q <= '0;
               end
            end
            S_HELD: begin
               // Other keys are ignored here, even on the same column.
               if (!key_down) begin
                  dbcnt_q <= '0;
                  state_q <= S_DEB_RELEASE;
               end
            end
            S_DEB_RELEASE: begin
               if (!db_last) begin
                  dbcnt_q <= dbcnt_q + DB_W'(1);
               end else if (!key_down) begin
                  state_q    <= S_SCAN;
                  col_q      <= col_inc;
                  col_n_q    <= col_drive(col_inc);
                  dwell_q    <= '0;
                  dbcnt_q    <= '0;
                  key_held_q <= 1'b0;
               end else begin
                  state_q <= S_HELD;
               end
            end
            default: begin
               state_q    <= S_SCAN;
               col_q      <= 2'd0;
               col_n_q    <= 4'b1110;
               dwell_q    <= '0;
               dbcnt_q    <= '0;
               key_held_q <= 1'b0;
            end
         endcase
      end
   end

   assign col_n     = col_n_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign digit_new = digit_new_q;
   assign digit_old = digit_old_q;

endmodule
